// File: rtl/aes128_round_ctrl.sv
// AES-128 encryption sequencer: initial AddRoundKey, on-the-fly key expansion and
// round sequencing around an external single-round combinational datapath.

module aes128_sbox32 (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the field inverse and maps 0 to 0, as the S-box needs.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        word_o = '0;
        for (int i = 0; i < 4; i++) begin
            word_o[8*i +: 8] = sub_byte(word_i[8*i +: 8]);
        end
    end
endmodule

module aes128_round_ctrl #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic [127:0] rnd_din,
    output logic [127:0] rnd_kin,
    output logic         rnd_sel,
    input  logic [127:0] rnd_dout
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] LAST_RND = 4'(NROUNDS);

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon;
    logic [31:0]  sub_w, t_w, w0_n, w1_n, w2_n, w3_n;
    logic         last_rnd;

    always_comb begin
        case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // SubWord(RotWord(w3)) for the next round key.
    aes128_sbox32 u_sbox (
        .word_i ({rk_q[23:0], rk_q[31:24]}),
        .word_o (sub_w)
    );

    assign t_w      = sub_w ^ {rcon, 24'h000000};
    assign w0_n     = rk_q[127:96] ^ t_w;
    assign w1_n     = rk_q[95:64]  ^ w0_n;
    assign w2_n     = rk_q[63:32]  ^ w1_n;
    assign w3_n     = rk_q[31:0]   ^ w2_n;
    assign last_rnd = (state_q == RUN) && (rnd_q == LAST_RND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_rnd)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        rk_d  = rk_q;
        ct_d  = ct_q;
        rnd_d = rnd_q;
        if (state_q == IDLE && in_valid) begin
            st_d  = pt ^ key;
            rk_d  = key;
            rnd_d = 4'd1;
        end else if (state_q == RUN) begin
            st_d  = rnd_dout;
            rk_d  = rnd_kin;
            // Counter parks at 0 after the last round so 11..15 never occur.
            rnd_d = last_rnd ? 4'd0 : rnd_q + 4'd1;
            if (last_rnd) ct_d = rnd_dout;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        ct        = ct_q;
        rnd_din   = st_q;
        rnd_kin   = {w0_n, w1_n, w2_n, w3_n};
        rnd_sel   = last_rnd;
    end
endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: models the external round datapath, scoreboards
// ciphertexts against a full AES-128 reference and checks handshake timing.

module tb_aes128_round_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;
    logic [127:0] rnd_din;
    logic [127:0] rnd_kin;
    logic         rnd_sel;
    logic [127:0] rnd_dout;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] B_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [127:0] exp_q[$];
    int           lat_q[$];
    logic [127:0] last_ct  = '0;
    logic         prev_ov  = 1'b0;
    bit           rand_done;

    aes128_round_ctrl #(.NROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct),
        .rnd_din   (rnd_din),
        .rnd_kin   (rnd_kin),
        .rnd_sel   (rnd_sel),
        .rnd_dout  (rnd_dout)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] c   = 8'h63;
        logic [7:0] b;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        for (int i = 0; i < 8; i++) begin
            b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                   inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        end
        return b;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*((c + w) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 8*(4*c)     -: 8];
            a1 = s[127 - 8*(4*c + 1) -: 8];
            a2 = s[127 - 8*(4*c + 2) -: 8];
            a3 = s[127 - 8*(4*c + 3) -: 8];
            r[127 - 8*(4*c)     -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
            r[127 - 8*(4*c + 1) -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
            r[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
            r[127 - 8*(4*c + 3) -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
        return r;
    endfunction

    function automatic logic [127:0] round_model(input logic [127:0] din, input logic [127:0] kin,
                                                 input logic fin);
        logic [127:0] s = shift_rows(sub_bytes(din));
        if (!fin) s = mix_columns(s);
        return s ^ kin;
    endfunction

    // Full cipher with a precomputed 44-word key schedule.
    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [31:0]  w[44];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t ^= {rc, 24'h0};
                rc = gmul(rc, 2);
            end
            w[i] = w[i-4] ^ t;
        end
        s = p ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_columns(s);
            s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    assign rnd_dout = round_model(rnd_din, rnd_kin, rnd_sel);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance side of the scoreboard.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(aes_ref(pt, key));
            lat_q.push_back(cyc);
        end
    end

    // Retirement side of the scoreboard.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_ct", {127'd0, out_valid}, 128'd0);
            else check("ct", ct, exp_q.pop_front());
            last_ct = ct;
        end
    end

    // out_valid must rise exactly 10 edges after acceptance.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (lat_q.size() == 0) check("spurious_valid", {127'd0, out_valid}, 128'd0);
            else check("latency", 128'(cyc - 1 - lat_q.pop_front()), 128'd10);
        end
        prev_ov = out_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] p, input logic [127:0] k, input bit hold,
                        output int acc_e);
        bit got = 1'b0;
        pt       = p;
        key      = k;
        in_valid = 1'b1;
        acc_e    = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            if (in_ready) begin
                got   = 1'b1;
                acc_e = cyc;
            end
        end
        #1;
        if (!hold) in_valid = 1'b0;
        if (!got) check("accept_timeout", {127'd0, got}, 128'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check("valid_seen", {127'd0, out_valid}, 128'd1);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- sequence ----------------
    initial begin
        int e0, e1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        pt        = '0;
        key       = '0;
        out_ready = 1'b0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_ct", ct, 128'd0);
        check("rst_rnd_din", rnd_din, 128'd0);
        check("rst_rnd_sel", {127'd0, rnd_sel}, 128'd0);

        // FIPS-197 App. B with round-key probes
        out_ready = 1'b1;
        send(B_PT, B_KEY, 1'b0, e0);
        @(negedge clk);
        check("b_kin_r1", rnd_kin, B_K1);
        check("b_sel_r1", {127'd0, rnd_sel}, 128'd0);
        repeat (9) @(negedge clk);
        check("b_kin_r10", rnd_kin, B_K10);
        check("b_sel_r10", {127'd0, rnd_sel}, 128'd1);
        wait_drain();
        check("b_fips_ct", last_ct, B_CT);

        // App. C.1 under 7 cycles of backpressure
        out_ready = 1'b0;
        send(C_PT, C_KEY, 1'b0, e0);
        wait_valid();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_ct", ct, C_CT);
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_retired", {127'd0, out_valid}, 128'd0);
        check("bp_in_ready_back", {127'd0, in_ready}, 128'd1);
        check("c_fips_ct", last_ct, C_CT);

        // Busy input: in_valid held with changing pt while running
        send(B_PT, B_KEY, 1'b1, e0);
        for (int i = 0; i < 5; i++) begin
            pt  = rand128();
            key = rand128();
            @(posedge clk);
            #1;
        end
        send(C_PT, C_KEY, 1'b0, e1);
        check("busy_gap", 128'(e1 - e0), 128'd12);
        wait_drain();
        check("busy_last_ct", last_ct, C_CT);

        // Reset around round 5
        send(C_PT, C_KEY, 1'b0, e0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_ct", ct, 128'd0);
        exp_q.delete();
        lat_q.delete();
        repeat (15) @(negedge clk);
        send(C_PT, C_KEY, 1'b0, e0);
        wait_drain();
        check("post_rst_ct", last_ct, C_CT);

        // Back-to-back with in_valid and out_ready held high
        send(B_PT, B_KEY, 1'b1, e0);
        send(C_PT, C_KEY, 1'b0, e1);
        check("b2b_gap", 128'(e1 - e0), 128'd12);
        wait_drain();
        check("b2b_last_ct", last_ct, C_CT);

        // Random vectors with random backpressure
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    send(rand128(), rand128(), 1'b0, e0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
